// File: rtl/telemetry_line_formatter.sv
//==============================================================================
// Module   : telemetry_line_formatter
// Function : Snapshots encoder/temperature/bill telemetry on request and emits
//            one 15-byte ASCII-hex line to a byte UART transmitter, obeying
//            the transmitter busy handshake. Optional change-only filtering.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module telemetry_line_formatter #(
    parameter int CHANGE_ONLY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send_req,
    input  logic [11:0] enc1_pos,
    input  logic [11:0] enc2_pos,
    input  logic [7:0]  temperature,
    input  logic [7:0]  bill_count,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        frame_busy,
    output logic        frame_done,
    output logic        req_dropped
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SEND = 3'd2,
        S_GAP  = 3'd3,
        S_WAIT = 3'd4
    } state_t;

    localparam logic [3:0] c_LAST_IDX = 4'd14;
    localparam logic [7:0] c_SPACE    = 8'h20;
    localparam logic [7:0] c_CR       = 8'h0D;
    localparam logic [7:0] c_LF       = 8'h0A;

    state_t      r_state;
    logic [39:0] r_snap;       // {enc1, enc2, temperature, bill}
    logic [39:0] r_last;       // payload of the last completed frame
    logic        r_last_vld;
    logic [3:0]  r_idx;
    logic        r_tx_start;
    logic [7:0]  r_tx_data;
    logic        r_frame_busy;
    logic        r_frame_done;
    logic        r_req_dropped;

    logic [39:0] w_live;
    logic        w_same;
    logic [7:0]  w_byte;

    assign w_live = {enc1_pos, enc2_pos, temperature, bill_count};
    // Change-only filtering looks at the live inputs on the request cycle.
    assign w_same = (CHANGE_ONLY != 0) && r_last_vld && (w_live == r_last);

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        else           return 8'h37 + {4'h0, n};
    endfunction

    // Select the character for the current byte index from the snapshot.
    always_comb begin
        w_byte = c_LF;
        case (r_idx)
            4'd0:    w_byte = hex_ascii(r_snap[39:36]);
            4'd1:    w_byte = hex_ascii(r_snap[35:32]);
            4'd2:    w_byte = hex_ascii(r_snap[31:28]);
            4'd3:    w_byte = c_SPACE;
            4'd4:    w_byte = hex_ascii(r_snap[27:24]);
            4'd5:    w_byte = hex_ascii(r_snap[23:20]);
            4'd6:    w_byte = hex_ascii(r_snap[19:16]);
            4'd7:    w_byte = c_SPACE;
            4'd8:    w_byte = hex_ascii(r_snap[15:12]);
            4'd9:    w_byte = hex_ascii(r_snap[11:8]);
            4'd10:   w_byte = c_SPACE;
            4'd11:   w_byte = hex_ascii(r_snap[7:4]);
            4'd12:   w_byte = hex_ascii(r_snap[3:0]);
            4'd13:   w_byte = c_CR;
            default: w_byte = c_LF;
        endcase
    end

    // Frame sequencer with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_snap        <= '0;
            r_last        <= '0;
            r_last_vld    <= 1'b0;
            r_idx         <= '0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= '0;
            r_frame_busy  <= 1'b0;
            r_frame_done  <= 1'b0;
            r_req_dropped <= 1'b0;
        end else begin
            r_tx_start    <= 1'b0;
            r_frame_done  <= 1'b0;
            r_req_dropped <= 1'b0;

            if (send_req && (r_state != S_IDLE)) begin
                r_req_dropped <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (send_req) begin
                        // A request coinciding with the completion pulse is
                        // treated as arriving before the FSM is back in IDLE.
                        if (r_frame_done || w_same) begin
                            r_req_dropped <= 1'b1;
                        end else begin
                            r_snap       <= w_live;
                            r_idx        <= '0;
                            r_frame_busy <= 1'b1;
                            r_state      <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    r_tx_data <= w_byte;
                    if (!tx_busy) begin
                        r_tx_start <= 1'b1;
                        r_state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    r_state <= S_GAP;
                end
                // Transmitter raises busy one cycle after the start strobe.
                S_GAP: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!tx_busy) begin
                        if (r_idx == c_LAST_IDX) begin
                            r_frame_done <= 1'b1;
                            r_frame_busy <= 1'b0;
                            r_last       <= r_snap;
                            r_last_vld   <= 1'b1;
                            r_state      <= S_IDLE;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_state <= S_LOAD;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_start    = r_tx_start;
    assign tx_data     = r_tx_data;
    assign frame_busy  = r_frame_busy;
    assign frame_done  = r_frame_done;
    assign req_dropped = r_req_dropped;

endmodule

`default_nettype wire

// File: tb/tb_telemetry_line_formatter.sv
//==============================================================================
// Module   : tb_telemetry_line_formatter
// Function : Directed bench for telemetry_line_formatter. Two instances
//            (CHANGE_ONLY=0 and =1), each with a model UART transmitter.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_telemetry_line_formatter;

    localparam logic [119:0] c_F1   = 120'h314133203046462031392030350D0A;
    localparam logic [119:0] c_F1A  = 120'h314133203046462031412030350D0A;
    localparam logic [119:0] c_HB   = 120'h303030204646462039412041390D0A;
    localparam logic [119:0] c_HB2  = 120'h303030204646462039412041410D0A;
    localparam int           c_BUSY = 23;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] enc1, enc2;
    logic [7:0]  temp, bill;
    logic [1:0]  send_req, tx_start, frame_busy, frame_done, req_dropped;
    logic [1:0]  force_busy = '0;
    logic [1:0]  pend = '0;
    logic [1:0]  mbusy = '0;
    logic [1:0]  tx_busy;
    logic [7:0]  tx_data [2];
    int          cnt [2];
    int          starts [2], fd [2], dr [2], viol [2];
    logic [7:0]  hold [2];
    logic [7:0]  q0 [$];
    logic [7:0]  q1 [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    assign tx_busy = mbusy | force_busy;

    telemetry_line_formatter #(.CHANGE_ONLY(0)) u_co0 (
        .clk(clk), .rst(rst), .send_req(send_req[0]),
        .enc1_pos(enc1), .enc2_pos(enc2), .temperature(temp), .bill_count(bill),
        .tx_busy(tx_busy[0]), .tx_start(tx_start[0]), .tx_data(tx_data[0]),
        .frame_busy(frame_busy[0]), .frame_done(frame_done[0]),
        .req_dropped(req_dropped[0])
    );

    telemetry_line_formatter #(.CHANGE_ONLY(1)) u_co1 (
        .clk(clk), .rst(rst), .send_req(send_req[1]),
        .enc1_pos(enc1), .enc2_pos(enc2), .temperature(temp), .bill_count(bill),
        .tx_busy(tx_busy[1]), .tx_start(tx_start[1]), .tx_data(tx_data[1]),
        .frame_busy(frame_busy[1]), .frame_done(frame_done[1]),
        .req_dropped(req_dropped[1])
    );

    // Model transmitter: busy rises one cycle after start, lasts c_BUSY cycles.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (pend[k]) begin
                pend[k]  <= 1'b0;
                mbusy[k] <= 1'b1;
                cnt[k]   <= c_BUSY;
            end else if (mbusy[k]) begin
                cnt[k] <= cnt[k] - 1;
                if (cnt[k] == 1) mbusy[k] <= 1'b0;
            end
            if (tx_start[k]) pend[k] <= 1'b1;
        end
    end

    // Monitor on the falling edge: capture bytes, count events, check handshake.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (tx_start[k]) begin
                if (k == 0) q0.push_back(tx_data[k]);
                else        q1.push_back(tx_data[k]);
                starts[k]++;
                if (tx_busy[k]) viol[k]++;
                hold[k] = tx_data[k];
            end else if ((pend[k] || mbusy[k]) && tx_data[k] !== hold[k]) begin
                viol[k]++;
            end
            if (frame_done[k])  fd[k]++;
            if (req_dropped[k]) dr[k]++;
        end
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req(input int k);
        send_req[k] = 1'b1;
        tick();
        send_req[k] = 1'b0;
    endtask

    function automatic logic [119:0] frame_of(input int k);
        logic [119:0] v = '0;
        logic [7:0]   b;
        for (int i = 0; i < 15; i++) begin
            if (k == 0) b = (i < q0.size()) ? q0[i] : 8'h00;
            else        b = (i < q1.size()) ? q1[i] : 8'h00;
            v = {v[111:0], b};
        end
        return v;
    endfunction

    task automatic clear_q(input int k);
        if (k == 0) q0.delete();
        else        q1.delete();
    endtask

    task automatic check_frame(input string tag, input int k, input logic [119:0] exp);
        int sz;
        sz = (k == 0) ? q0.size() : q1.size();
        check_val({tag, "_len"}, sz, 15);
        check_val(tag, frame_of(k), exp);
    endtask

    task automatic wait_done(input string tag, input int k);
        int n = 0;
        while (frame_done[k] !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        check_val({tag, "_done_seen"}, (n < 3000), 1);
        tick();
    endtask

    task automatic wait_starts(input int k, input int target);
        int n = 0;
        while (starts[k] < target && n < 3000) begin
            tick();
            n++;
        end
        check_val("start_wait", (n < 3000), 1);
    endtask

    task automatic set_in(input logic [11:0] e1, input logic [11:0] e2,
                          input logic [7:0] t, input logic [7:0] b);
        enc1 = e1; enc2 = e2; temp = t; bill = b;
    endtask

    initial begin
        int bs, bd, n;
        for (int k = 0; k < 2; k++) begin
            starts[k] = 0; fd[k] = 0; dr[k] = 0; viol[k] = 0; hold[k] = '0;
        end
        rst = 1'b1;
        send_req = '0;
        set_in(12'h1A3, 12'h0FF, 8'h19, 8'h05);
        repeat (3) tick();
        check_val("rst_outs0", {tx_start[0], frame_busy[0], frame_done[0], req_dropped[0], tx_data[0]}, 0);
        check_val("rst_outs1", {tx_start[1], frame_busy[1], frame_done[1], req_dropped[1], tx_data[1]}, 0);
        rst = 1'b0;
        tick();

        // Basic frame on CHANGE_ONLY=0 with minimum-latency check.
        send_req[0] = 1'b1;
        tick();
        send_req[0] = 1'b0;
        check_val("lat_cycle1", tx_start[0], 0);
        check_val("busy_cycle1", frame_busy[0], 1);
        tick();
        check_val("lat_cycle2", tx_start[0], 1);
        // Request coinciding with frame_done is dropped.
        n = 0;
        while (frame_done[0] !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        check_val("basic_done_seen", (n < 3000), 1);
        pulse_req(0);
        repeat (50) tick();
        check_frame("basic_frame", 0, c_F1);
        check_val("basic_starts", starts[0], 15);
        check_val("basic_fd", fd[0], 1);
        check_val("done_cycle_drop", dr[0], 1);
        check_val("basic_idle_busy", frame_busy[0], 0);

        // CHANGE_ONLY=0 resends identical payload.
        clear_q(0);
        pulse_req(0);
        wait_done("resend", 0);
        check_frame("resend_frame", 0, c_F1);
        check_val("resend_starts", starts[0], 30);

        // Change-only: first sent, identical second dropped, changed one sent.
        clear_q(1);
        pulse_req(1);
        wait_done("co_first", 1);
        check_frame("co_first_frame", 1, c_F1);
        repeat (5000) tick();
        bs = starts[1]; bd = dr[1];
        pulse_req(1);
        repeat (50) tick();
        check_val("co_dup_drop", dr[1], bd + 1);
        check_val("co_dup_nostart", starts[1], bs);
        temp = 8'h1A;
        clear_q(1);
        pulse_req(1);
        wait_done("co_change", 1);
        check_frame("co_change_frame", 1, c_F1A);

        // Request while busy, plus snapshot isolation from mid-frame input change.
        temp = 8'h19;
        clear_q(1);
        bs = starts[1]; bd = dr[1];
        pulse_req(1);
        wait_starts(1, bs + 6);
        pulse_req(1);
        enc1 = 12'hFFF;
        tick();
        check_val("busy_req_drop", dr[1], bd + 1);
        wait_done("isolate", 1);
        check_frame("isolate_frame", 1, c_F1);

        // Hex digit boundaries.
        set_in(12'h000, 12'hFFF, 8'h9A, 8'hA9);
        clear_q(1);
        pulse_req(1);
        wait_done("hexb", 1);
        check_frame("hexb_frame", 1, c_HB);

        // Transmitter busy when request arrives.
        bill = 8'hAA;
        force_busy[1] = 1'b1;
        clear_q(1);
        bs = starts[1];
        pulse_req(1);
        repeat (40) tick();
        check_val("hold_nostart", starts[1], bs);
        check_val("hold_frame_busy", frame_busy[1], 1);
        force_busy[1] = 1'b0;
        wait_done("hold", 1);
        check_frame("hold_frame", 1, c_HB2);
        check_val("handshake_viol0", viol[0], 0);
        check_val("handshake_viol1", viol[1], 0);

        // Reset during byte 7, then identical-to-last payload must send again.
        set_in(12'h1A3, 12'h0FF, 8'h19, 8'h05);
        bs = starts[1];
        pulse_req(1);
        wait_starts(1, bs + 8);
        rst = 1'b1;
        tick();
        check_val("abort_tx_start", tx_start[1], 0);
        check_val("abort_frame_busy", frame_busy[1], 0);
        rst = 1'b0;
        n = 0;
        while ((mbusy[1] || pend[1]) && n < 200) begin
            tick();
            n++;
        end
        set_in(12'h000, 12'hFFF, 8'h9A, 8'hAA);
        clear_q(1);
        pulse_req(1);
        wait_done("after_rst", 1);
        check_frame("after_rst_frame", 1, c_HB2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/telemetry_line_formatter.md
Name: telemetry_line_formatter

Overview:
- Upstream feeder for the 230400-baud async_transmitter on the host UART link.
- Replaces ad-hoc timer-slot byte sequencing with a handshaked frame formatter.
- On request, snapshots encoder 1/2 positions, DS18B20 temperature and bill-acceptor count, then emits one ASCII-hex text line, byte by byte, obeying transmitter busy.
- Optional change-only mode suppresses frames whose payload equals the last frame sent.

Parameters:
- CHANGE_ONLY, 1, 1 = drop a request when the snapshot equals the last transmitted payload; 0 = always send.

Ports:
- clk  input  1  system clock (10 MHz board clock)
- rst  input  1  synchronous, active-high reset
- send_req  input  1  one-cycle frame request pulse (periodic tick from timer)
- enc1_pos  input  12  encoder 1 position
- enc2_pos  input  12  encoder 2 position
- temperature  input  8  DS18B20 temperature byte
- bill_count  input  8  accumulated bill value
- tx_busy  input  1  transmitter busy (TxD_busy)
- tx_start  output  1  one-cycle byte start strobe (TxD_start)
- tx_data  output  8  byte to transmit (TxD_data); held stable while the byte is in flight
- frame_busy  output  1  high from snapshot until last byte completes
- frame_done  output  1  one-cycle pulse when the last byte's tx_busy falls
- req_dropped  output  1  one-cycle pulse when send_req is ignored (busy or unchanged)

Behaviour:
- Reset: all outputs 0; FSM in IDLE; byte index 0; last-sent valid flag cleared.
- rst has priority over every event. Asserting it mid-frame aborts the frame; the next cycle has tx_start=0, frame_busy=0. A byte already handed to the transmitter completes on its own.
- Frame is 15 bytes, in order:
  - E1[11:8], E1[7:4], E1[3:0], ' '
  - E2[11:8], E2[7:4], E2[3:0], ' '
  - T[7:4], T[3:0], ' '
  - B[7:4], B[3:0], CR (0x0D), LF (0x0A)
- Hex encoding: nibble 0–9 → 0x30+n; A–F → 0x37+n (uppercase).
- FSM states: IDLE, LOAD, SEND, GAP, WAIT.
  - IDLE: on send_req, capture all four inputs into snapshot registers (same edge). Go to LOAD, or stay in IDLE with req_dropped=1 when CHANGE_ONLY=1, valid flag set and snapshot equals last-sent.
  - In CHANGE_ONLY mode the comparison uses the inputs present on the send_req cycle.
  - LOAD: set tx_data from snapshot and byte index. frame_busy=1. Go to SEND when tx_busy=0, otherwise hold.
  - SEND: tx_start=1 for exactly one cycle → GAP.
  - GAP: one cycle, covers the transmitter's one-cycle busy-rise latency → WAIT.
  - WAIT: hold until tx_busy=0.
    - If index=14: pulse frame_done, copy snapshot to last-sent, set valid flag, return to IDLE.
    - Otherwise increment index and go to LOAD.
- Minimum latency: send_req at cycle 0 → first tx_start at cycle 2 when tx_busy is low.
- send_req in any state other than IDLE: ignored, req_dropped=1 that cycle, snapshot unchanged.
- Input changes mid-frame do not affect the frame in progress.
- tx_busy stuck high: FSM waits indefinitely (no timeout); rst recovers it.
- send_req on the same cycle as frame_done: dropped (FSM not yet in IDLE).
- Byte index is 4 bits and never exceeds 14.
- Last-sent/valid update happens only on frame_done; an aborted frame never updates it.

Test Plan:
- Basic frame: CHANGE_ONLY=0, enc1=0x1A3, enc2=0x0FF, temp=0x19, bill=0x05, model transmitter 23 busy cycles/byte, pulse send_req → bytes 31 41 33 20 30 46 46 20 31 39 20 30 35 0D 0A, 15 tx_start pulses, one frame_done after the final busy fall.
- Change-only suppression: CHANGE_ONLY=1, same inputs, two requests 5000 cycles apart → first sends 15 bytes; second gives req_dropped=1 and no tx_start. Change temp to 0x1A, request → frame sent with bytes 9–10 = 31 41.
- Request while busy plus snapshot isolation: send_req at byte 5 → req_dropped pulse; change enc1 to 0xFFF mid-frame → current frame still carries 31 41 33.
- Hex boundaries: enc1=0x000, enc2=0xFFF, temp=0x9A, bill=0xA9 → 30 30 30 20 46 46 46 20 39 41 20 41 39 0D 0A.
- Handshake timing: tx_busy held high when the request arrives → no tx_start until busy low. tx_start is never asserted while tx_busy=1. tx_data is constant from tx_start to busy fall.
- Reset mid-frame: rst during byte 7 → next cycle tx_start=0, frame_busy=0. With CHANGE_ONLY=1, a new request with identical inputs sends the full frame (valid flag cleared).
